multicycle_ctrl: RTL

//  Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and

---
 rtl/riscv_pkg.sv | 61 ++++++
 rtl/mem_req_timer.sv | 46 ++++
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the multi-cycle RV32I core: major opcodes, the
//   control FSM state encoding, datapath mux/ALU-op encodings and a helper
//   that tells whether an opcode belongs to the supported RV32I subset.
//   Used by the control FSM, the decoder and the datapath.
// ---------------------------------------------------------------------------
package riscv_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Control FSM states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Write-back source select
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  // ALU operand A select
  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_BR    = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  function automatic logic opcode_legal(input logic [6:0] opc);
    logic legal;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: legal = 1'b1;
      default:                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_req_timer.sv
// ---------------------------------------------------------------------------
// mem_req_timer
//   Counts consecutive cycles a memory request is left waiting and flags the
//   cycle in which one more wait would exceed TIMEOUT_CYC request cycles.
//   Ports:
//     iClk     clock, rising edge
//     iRst     asynchronous active-high reset
//     iReq     memory request is being presented this cycle
//     iReady   memory completes the transfer this cycle
//     oExpire  this is a wait cycle with TIMEOUT_CYC-1 waits already counted
//   TIMEOUT_CYC must be >= 1.
// ---------------------------------------------------------------------------
module mem_req_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iReq,
  input  logic iReady,
  output logic oExpire
);

  localparam int            CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q, count_d;
  logic          waiting;

  assign waiting = iReq & ~iReady;

  // Any cycle that is not a wait (an accept, or a state without a request)
  // clears the count, so every request state is entered with a count of 0.
  always_comb begin
    count_d = waiting ? count_q + CW'(1) : '0;
  end

  assign oExpire = waiting && (count_q == LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM of the multi-cycle RV32I core: FETCH, DECODE, EXEC, MEM, WB
//   and a sticky TRAP. Owns the shared instruction/data memory handshake and
//   drives IR/PC/regfile enables and datapath mux selects.
//   Ports:
//     iClk, iRst           clock / asynchronous active-high reset
//     iOpcode, iFunct3     decoder fields (IR-held, valid from DECODE)
//     iBrTaken             branch comparator result, used in EXEC
//     iMemReady            memory completes the transfer this cycle
//     oMemReq/oMemWe       memory request / store strobe
//     oAddrSel             0=PC, 1=ALU result
//     oIrWe, oPcWe, oPcSel IR load, PC update, PC source (0=PC+4, 1=ALU)
//     oRegWe, oWbSel       regfile write enable / write-back source
//     oAluSrcA/B, oAluOp   ALU operand selects and operation class
//     oDone                one-cycle pulse on instruction retire
//     oTrap                sticky illegal-opcode / memory-timeout flag
//     oState               current FSM state (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [6:0] iOpcode,
  input  logic [2:0] iFunct3,
  input  logic       iBrTaken,
  input  logic       iMemReady,
  output logic       oMemReq,
  output logic       oMemWe,
  output logic       oAddrSel,
  output logic       oIrWe,
  output logic       oPcWe,
  output logic       oPcSel,
  output logic       oRegWe,
  output logic [1:0] oWbSel,
  output logic [1:0] oAluSrcA,
  output logic [1:0] oAluSrcB,
  output logic [1:0] oAluOp,
  output logic       oDone,
  output logic       oTrap,
  output logic [2:0] oState
);

  state_e     state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic       mem_req;
  logic       expire;
  logic       is_load, is_store, is_jump;

  // funct3 only steers the ALU's own decode; the sequencing here depends on
  // the opcode alone.
  logic unused_funct3;
  assign unused_funct3 = ^iFunct3;

  assign mem_req  = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign is_load  = (opcode_q == OPC_LOAD);
  assign is_store = (opcode_q == OPC_STORE);
  assign is_jump  = (opcode_q == OPC_JAL) || (opcode_q == OPC_JALR);

  mem_req_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .iClk    (iClk),
    .iRst    (iRst),
    .iReq    (mem_req),
    .iReady  (iMemReady),
    .oExpire (expire)
  );

  // State register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state logic. A ready memory in the last allowed wait cycle wins
  // over the timeout.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    unique case (state_q)
      ST_FETCH: begin
        if (iMemReady)   state_d = ST_DECODE;
        else if (expire) state_d = ST_TRAP;
      end
      ST_DECODE: begin
        opcode_d = iOpcode;
        state_d  = opcode_legal(iOpcode) ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        if (opcode_q == OPC_BRANCH)  state_d = ST_FETCH;
        else if (is_load | is_store) state_d = ST_MEM;
        else                         state_d = ST_WB;
      end
      ST_MEM: begin
        if (iMemReady)   state_d = is_load ? ST_WB : ST_FETCH;
        else if (expire) state_d = ST_TRAP;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  // Output logic. Outputs are held low while reset is asserted so a
  // transfer in flight is dropped immediately, not at the next edge.
  always_comb begin
    // NOTE: every output is given a default before the case so that no path
    // leaves one unassigned and infers a latch.
    oMemReq  = 1'b0;
    oMemWe   = 1'b0;
    oAddrSel = 1'b0;
    oIrWe    = 1'b0;
    oPcWe    = 1'b0;
    oPcSel   = 1'b0;
    oRegWe   = 1'b0;
    oWbSel   = WB_ALU;
    oAluSrcA = SRCA_RS1;
    oAluSrcB = SRCB_RS2;
    oAluOp   = ALUOP_ADD;
    oDone    = 1'b0;
    oTrap    = 1'b0;
    oState   = state_q;
    if (!iRst) begin
      unique case (state_q)
        ST_FETCH: begin
          oMemReq = 1'b1;
          oIrWe   = iMemReady;
        end
        ST_DECODE: ;
        ST_EXEC: begin
          case (opcode_q)
            OPC_OP:     oAluOp = ALUOP_FUNCT;
            OPC_OP_IMM: begin oAluSrcB = SRCB_IMM; oAluOp = ALUOP_FUNCT; end
            OPC_LUI:    begin oAluSrcA = SRCA_ZERO; oAluSrcB = SRCB_IMM; end
            OPC_AUIPC,
            OPC_JAL:    begin oAluSrcA = SRCA_PC; oAluSrcB = SRCB_IMM; end
            OPC_JALR,
            OPC_LOAD,
            OPC_STORE:  oAluSrcB = SRCB_IMM;
            OPC_BRANCH: begin
              oAluOp = ALUOP_BR;
              oPcWe  = 1'b1;
              oPcSel = iBrTaken;
              oDone  = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          oMemReq  = 1'b1;
          oAddrSel = 1'b1;
          oMemWe   = is_store;
          if (iMemReady && is_store) begin
            oPcWe = 1'b1;
            oDone = 1'b1;
          end
        end
        ST_WB: begin
          oRegWe = 1'b1;
          oWbSel = is_load ? WB_MEM : (is_jump ? WB_PC4 : WB_ALU);
          oPcWe  = 1'b1;
          oPcSel = is_jump;  // jump target was captured in ALUOut during EXEC
          oDone  = 1'b1;
        end
        ST_TRAP: oTrap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
